// File: rtl/fifo_wr_arbiter.sv
// -----------------------------------------------------------------------------
// fifo_wr_arbiter
//
// Round-robin arbiter that shares one FIFO write port among NUM_REQ producers.
// Each producer offers a valid/ready stream. The winning producer's beat is
// forwarded combinationally to the FIFO (zero-cycle latency). Arbitration
// state updates on the clock edge after each transfer.
//
// Build option:
//   FIFO_WR_ARB_BURST_EN  defined   : the winner of an IDLE grant keeps the port
//                                     for up to MAX_BURST beats (BURST state).
//                         undefined : every beat is arbitrated independently
//                                     (strict per-beat round-robin). MAX_BURST
//                                     is ignored and o_busy is tied low.
//
// Ports:
//   clk          clock, all logic on the rising edge
//   rstn         synchronous active-low reset (no write while low)
//   i_req_valid  per-producer beat valid
//   i_req_data   flattened beats, producer k at [k*DATA_W +: DATA_W]
//   o_req_ready  per-producer accept, one-hot or zero
//   i_full       FIFO full, suppresses any write
//   o_wren       FIFO write enable
//   o_wrdata     FIFO write data, zero when no write
//   o_grant_id   index of the producer written this cycle, zero when no write
//   o_busy       registered, high while the arbiter is in the BURST state
// -----------------------------------------------------------------------------
module fifo_wr_arbiter #(
   parameter int NUM_REQ   = 4,
   parameter int DATA_W    = 128,
   parameter int MAX_BURST = 4
) (
   input  logic                       clk,
   input  logic                       rstn,
   input  logic [NUM_REQ-1:0]         i_req_valid,
   input  logic [NUM_REQ*DATA_W-1:0]  i_req_data,
   output logic [NUM_REQ-1:0]         o_req_ready,
   input  logic                       i_full,
   output logic                       o_wren,
   output logic [DATA_W-1:0]          o_wrdata,
   output logic [$clog2(NUM_REQ)-1:0] o_grant_id,
   output logic                       o_busy
);

   localparam int IDX_W = $clog2(NUM_REQ);

   logic [DATA_W-1:0] req_data [NUM_REQ];
   logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_d;
   logic [IDX_W-1:0]  win_idx, rr_next;
   logic              win_found;
   logic [IDX_W-1:0]  cand_idx;
   logic              cand_valid;
   logic              xfer;

   for (genvar k = 0; k < NUM_REQ; k++) begin : g_unpack
      assign req_data[k] = i_req_data[k*DATA_W +: DATA_W];
   end

   // First valid producer scanning from rr_ptr upward, wrapping at NUM_REQ.
   always_comb begin
      logic [IDX_W:0]   scan_sum;
      logic [IDX_W-1:0] scan_idx;
      // NOTE: every combinational output gets a default before any branch so
      // no path leaves it unassigned, which would otherwise infer a latch.
      win_found = 1'b0;
      win_idx   = '0;
      scan_sum  = '0;
      scan_idx  = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         scan_sum = {1'b0, rr_ptr_q} + (IDX_W+1)'(i);
         if (scan_sum >= (IDX_W+1)'(NUM_REQ)) scan_sum = scan_sum - (IDX_W+1)'(NUM_REQ);
         scan_idx = scan_sum[IDX_W-1:0];
         if (!win_found && i_req_valid[scan_idx]) begin
            win_found = 1'b1;
            win_idx   = scan_idx;
         end
      end
   end

   assign rr_next = (win_idx == IDX_W'(NUM_REQ-1)) ? '0 : win_idx + IDX_W'(1);

   // Writes are gated by rstn so nothing reaches the FIFO during reset,
   // whatever the producers present.
   assign xfer = rstn & cand_valid & ~i_full;

   always_comb begin
      o_wren      = xfer;
      o_req_ready = '0;
      o_grant_id  = '0;
      o_wrdata    = '0;
      if (xfer) begin
         o_req_ready[cand_idx] = 1'b1;
         o_grant_id            = cand_idx;
         o_wrdata              = req_data[cand_idx];
      end
   end

`ifdef FIFO_WR_ARB_BURST_EN

   localparam int CNT_W = $clog2(MAX_BURST+1);

   typedef enum logic {ST_IDLE, ST_BURST} state_e;

   state_e           state_q, state_d;
   logic [IDX_W-1:0] owner_q, owner_d;
   logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;
   logic [CNT_W-1:0] cnt_inc;
   logic             busy_q, busy_d;

   // During a burst only the owner is eligible; others wait for IDLE.
   always_comb begin
      if (state_q == ST_BURST) begin
         cand_idx   = owner_q;
         cand_valid = i_req_valid[owner_q];
      end else begin
         cand_idx   = win_idx;
         cand_valid = win_found;
      end
   end

   assign cnt_inc = beat_cnt_q + CNT_W'(1);

   always_comb begin
      state_d    = state_q;
      rr_ptr_d   = rr_ptr_q;
      owner_d    = owner_q;
      beat_cnt_d = beat_cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (xfer) begin
               rr_ptr_d   = rr_next;
               owner_d    = win_idx;
               beat_cnt_d = CNT_W'(1);
               if (MAX_BURST > 1) state_d = ST_BURST;
            end
         end
         ST_BURST: begin
            // An owner that goes quiet loses the port even if the FIFO is
            // full; the release cycle itself writes nothing.
            if (!i_req_valid[owner_q]) begin
               state_d    = ST_IDLE;
               beat_cnt_d = '0;
            end else if (xfer) begin
               if (cnt_inc == CNT_W'(MAX_BURST)) begin
                  state_d    = ST_IDLE;
                  beat_cnt_d = '0;
               end else begin
                  beat_cnt_d = cnt_inc;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
      busy_d = (state_d == ST_BURST);
   end

   always_ff @(posedge clk) begin
      // NOTE: reset is synchronous, so it is tested inside the clocked block
      // and rstn stays out of the sensitivity list.
      if (!rstn) begin
         // NOTE: sequential state uses non-blocking assignments so every flop
         // samples the pre-edge values regardless of statement order.
         state_q    <= ST_IDLE;
         rr_ptr_q   <= '0;
         owner_q    <= '0;
         beat_cnt_q <= '0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         rr_ptr_q   <= rr_ptr_d;
         owner_q    <= owner_d;
         beat_cnt_q <= beat_cnt_d;
         busy_q     <= busy_d;
      end
   end

   assign o_busy = busy_q;

`else

   // MAX_BURST has no effect in this build.
   logic unused_max_burst;
   assign unused_max_burst = (MAX_BURST > 0);

   assign cand_idx   = win_idx;
   assign cand_valid = win_found;

   always_comb begin
      rr_ptr_d = rr_ptr_q;
      if (xfer) rr_ptr_d = rr_next;
   end

   always_ff @(posedge clk) begin
      if (!rstn) rr_ptr_q <= '0;
      else       rr_ptr_q <= rr_ptr_d;
   end

   assign o_busy = 1'b0;

`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_fifo_wr_arbiter
//
// Directed bench for fifo_wr_arbiter (NUM_REQ=4, DATA_W=128, MAX_BURST=4).
// Each cycle's stimulus carries its expected outcome; the expectation is
// queued when the stimulus is driven and popped and compared on the falling
// edge, when the combinational outputs are settled. Expected sequences follow
// the burst build when FIFO_WR_ARB_BURST_EN is defined, else per-beat RR.
// -----------------------------------------------------------------------------
module tb_fifo_wr_arbiter;

   localparam int NUM_REQ   = 4;
   localparam int DATA_W    = 128;
   localparam int MAX_BURST = 4;

   typedef struct packed {
      logic       rstn;
      logic [3:0] valid;
      logic       full;
      logic       wren;   // expected
      logic [1:0] id;     // expected
      logic       busy;   // expected
   } cyc_t;

   typedef logic [1+2+1+NUM_REQ+DATA_W-1:0] obs_t;

   logic                      clk;
   logic                      rstn;
   logic [NUM_REQ-1:0]        i_req_valid;
   logic [NUM_REQ*DATA_W-1:0] i_req_data;
   logic [NUM_REQ-1:0]        o_req_ready;
   logic                      i_full;
   logic                      o_wren;
   logic [DATA_W-1:0]         o_wrdata;
   logic [1:0]                o_grant_id;
   logic                      o_busy;

   int   checks = 0;
   int   errors = 0;
   cyc_t exp_q [$];

   fifo_wr_arbiter #(
      .NUM_REQ   (NUM_REQ),
      .DATA_W    (DATA_W),
      .MAX_BURST (MAX_BURST)
   ) dut (
      .clk         (clk),
      .rstn        (rstn),
      .i_req_valid (i_req_valid),
      .i_req_data  (i_req_data),
      .o_req_ready (o_req_ready),
      .i_full      (i_full),
      .o_wren      (o_wren),
      .o_wrdata    (o_wrdata),
      .o_grant_id  (o_grant_id),
      .o_busy      (o_busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [DATA_W-1:0] data_of(input int k);
      return {32'hD47A_0000 + 32'(k), 32'hBEEF_0000 ^ 32'(k << 4), 32'(k*17 + 3), 32'(k)};
   endfunction

   function automatic cyc_t mk(input bit r, input bit [3:0] v, input bit f,
                               input bit w, input int id, input bit b);
      cyc_t c;
      c.rstn = r; c.valid = v; c.full = f; c.wren = w; c.id = 2'(id); c.busy = b;
      return c;
   endfunction

   // Expected observation: ready is one-hot on the granted producer and the
   // data is that producer's beat; both are zero when nothing is written.
   function automatic obs_t exp_vec(input cyc_t c);
      logic [NUM_REQ-1:0] rdy;
      logic [DATA_W-1:0]  dat;
      rdy = '0;
      dat = '0;
      if (c.wren) begin
         rdy[c.id] = 1'b1;
         dat       = data_of(int'(c.id));
      end
      return {c.wren, c.id, c.busy, rdy, dat};
   endfunction

   // Drive one cycle of stimulus just after the rising edge and queue its
   // expectation.
   task automatic drive_cycle(input cyc_t c);
      @(posedge clk);
      #1;
      rstn        = c.rstn;
      i_req_valid = c.valid;
      i_full      = c.full;
      exp_q.push_back(c);
   endtask

   task automatic test_reset();
      cyc_t seq [$];
      cyc_t e;
      obs_t o, x;
      for (int n = 0; n < 3; n++) seq.push_back(mk(0, 4'hF, 0, 0, 0, 0));
      seq.push_back(mk(1, 4'hF, 0, 1, 0, 0));
`ifdef FIFO_WR_ARB_BURST_EN
      for (int n = 0; n < 3; n++) seq.push_back(mk(1, 4'hF, 0, 1, 0, 1));
`endif
      foreach (seq[n]) begin
         drive_cycle(seq[n]);
         @(negedge clk);
         e = exp_q.pop_front();
         o = {o_wren, o_grant_id, o_busy, o_req_ready, o_wrdata};
         x = exp_vec(e);
         checks++;
         if (o !== x) begin
            errors++;
            $display("FAIL reset cyc%0d: got wren=%0b id=%0d busy=%0b rdy=%b data=%h, expected wren=%0b id=%0d busy=%0b rdy=%b data=%h",
                     n, o[135], o[134:133], o[132], o[131:128], o[127:0],
                     x[135], x[134:133], x[132], x[131:128], x[127:0]);
         end
      end
   endtask

`ifdef FIFO_WR_ARB_BURST_EN
   task automatic test_burst();
      cyc_t seq [$];
      cyc_t e;
      obs_t o, x;
      for (int r = 0; r < 3; r++) begin
         int id;
         id = (r == 1) ? 2 : 1;
         seq.push_back(mk(1, 4'b0110, 0, 1, id, 0));
         for (int n = 0; n < 3; n++) seq.push_back(mk(1, 4'b0110, 0, 1, id, 1));
      end
      foreach (seq[n]) begin
         drive_cycle(seq[n]);
         @(negedge clk);
         e = exp_q.pop_front();
         o = {o_wren, o_grant_id, o_busy, o_req_ready, o_wrdata};
         x = exp_vec(e);
         checks++;
         if (o !== x) begin
            errors++;
            $display("FAIL burst cyc%0d: got wren=%0b id=%0d busy=%0b rdy=%b data=%h, expected wren=%0b id=%0d busy=%0b rdy=%b data=%h",
                     n, o[135], o[134:133], o[132], o[131:128], o[127:0],
                     x[135], x[134:133], x[132], x[131:128], x[127:0]);
         end
      end
   endtask

   task automatic test_owner_drop();
      cyc_t seq [$];
      cyc_t e;
      obs_t o, x;
      // Producer 0 drops after two beats; producer 3 takes the next burst.
      seq.push_back(mk(1, 4'b0001, 0, 1, 0, 0));
      seq.push_back(mk(1, 4'b1001, 0, 1, 0, 1));
      seq.push_back(mk(1, 4'b1000, 0, 0, 0, 1));
      seq.push_back(mk(1, 4'b1000, 0, 1, 3, 0));
      for (int n = 0; n < 3; n++) seq.push_back(mk(1, 4'b1000, 0, 1, 3, 1));
      // Drop while the FIFO is full still releases the port.
      seq.push_back(mk(1, 4'b0001, 0, 1, 0, 0));
      seq.push_back(mk(1, 4'b0001, 1, 0, 0, 1));
      seq.push_back(mk(1, 4'b0000, 1, 0, 0, 1));
      seq.push_back(mk(1, 4'b0010, 0, 1, 1, 0));
      seq.push_back(mk(1, 4'b0000, 0, 0, 0, 1));
      seq.push_back(mk(1, 4'b0000, 0, 0, 0, 0));
      // With producers 1 and 3 both waiting, producer 1 wins after the drop.
      seq.push_back(mk(1, 4'b0001, 0, 1, 0, 0));
      seq.push_back(mk(1, 4'b1011, 0, 1, 0, 1));
      seq.push_back(mk(1, 4'b1010, 0, 0, 0, 1));
      seq.push_back(mk(1, 4'b1010, 0, 1, 1, 0));
      for (int n = 0; n < 3; n++) seq.push_back(mk(1, 4'b1010, 0, 1, 1, 1));
      foreach (seq[n]) begin
         drive_cycle(seq[n]);
         @(negedge clk);
         e = exp_q.pop_front();
         o = {o_wren, o_grant_id, o_busy, o_req_ready, o_wrdata};
         x = exp_vec(e);
         checks++;
         if (o !== x) begin
            errors++;
            $display("FAIL owner_drop cyc%0d: got wren=%0b id=%0d busy=%0b rdy=%b data=%h, expected wren=%0b id=%0d busy=%0b rdy=%b data=%h",
                     n, o[135], o[134:133], o[132], o[131:128], o[127:0],
                     x[135], x[134:133], x[132], x[131:128], x[127:0]);
         end
      end
   endtask
`else
   task automatic test_round_robin();
      cyc_t seq [$];
      cyc_t e;
      obs_t o, x;
      int   ids [5] = '{1, 2, 3, 0, 1};
      foreach (ids[n]) seq.push_back(mk(1, 4'hF, 0, 1, ids[n], 0));
      for (int n = 0; n < 4; n++) seq.push_back(mk(1, 4'b1001, 0, 1, (n % 2 == 0) ? 3 : 0, 0));
      seq.push_back(mk(1, 4'b0001, 0, 1, 0, 0));   // scan wraps past 3 to 0
      seq.push_back(mk(1, 4'b0010, 0, 1, 1, 0));
      seq.push_back(mk(1, 4'b0010, 0, 1, 1, 0));
      seq.push_back(mk(1, 4'b0000, 0, 0, 0, 0));
      foreach (seq[n]) begin
         drive_cycle(seq[n]);
         @(negedge clk);
         e = exp_q.pop_front();
         o = {o_wren, o_grant_id, o_busy, o_req_ready, o_wrdata};
         x = exp_vec(e);
         checks++;
         if (o !== x) begin
            errors++;
            $display("FAIL round_robin cyc%0d: got wren=%0b id=%0d busy=%0b rdy=%b data=%h, expected wren=%0b id=%0d busy=%0b rdy=%b data=%h",
                     n, o[135], o[134:133], o[132], o[131:128], o[127:0],
                     x[135], x[134:133], x[132], x[131:128], x[127:0]);
         end
      end
   endtask
`endif

   task automatic test_full();
      cyc_t seq [$];
      cyc_t e;
      obs_t o, x;
`ifdef FIFO_WR_ARB_BURST_EN
      seq.push_back(mk(1, 4'b0001, 0, 1, 0, 0));
      seq.push_back(mk(1, 4'b0001, 0, 1, 0, 1));
      for (int n = 0; n < 3; n++) seq.push_back(mk(1, 4'b0001, 1, 0, 0, 1));
      seq.push_back(mk(1, 4'b0011, 0, 1, 0, 1));
      seq.push_back(mk(1, 4'b0011, 0, 1, 0, 1));
      seq.push_back(mk(1, 4'b0011, 0, 1, 1, 0));
      for (int n = 0; n < 3; n++) seq.push_back(mk(1, 4'b0011, 0, 1, 1, 1));
`else
      for (int n = 0; n < 3; n++) seq.push_back(mk(1, 4'hF, 1, 0, 0, 0));
      seq.push_back(mk(1, 4'hF, 0, 1, 2, 0));
      seq.push_back(mk(1, 4'hF, 0, 1, 3, 0));
`endif
      foreach (seq[n]) begin
         drive_cycle(seq[n]);
         @(negedge clk);
         e = exp_q.pop_front();
         o = {o_wren, o_grant_id, o_busy, o_req_ready, o_wrdata};
         x = exp_vec(e);
         checks++;
         if (o !== x) begin
            errors++;
            $display("FAIL full cyc%0d: got wren=%0b id=%0d busy=%0b rdy=%b data=%h, expected wren=%0b id=%0d busy=%0b rdy=%b data=%h",
                     n, o[135], o[134:133], o[132], o[131:128], o[127:0],
                     x[135], x[134:133], x[132], x[131:128], x[127:0]);
         end
      end
   endtask

   task automatic test_mid_reset();
      cyc_t seq [$];
      cyc_t e;
      obs_t o, x;
`ifdef FIFO_WR_ARB_BURST_EN
      seq.push_back(mk(1, 4'b0100, 0, 1, 2, 0));
      seq.push_back(mk(1, 4'b0100, 0, 1, 2, 1));
      seq.push_back(mk(0, 4'b0101, 0, 0, 0, 1));
      seq.push_back(mk(1, 4'b0101, 0, 1, 0, 0));
      seq.push_back(mk(1, 4'b0101, 0, 1, 0, 1));
`else
      seq.push_back(mk(1, 4'hF, 0, 1, 0, 0));
      seq.push_back(mk(1, 4'hF, 0, 1, 1, 0));
      seq.push_back(mk(0, 4'hF, 0, 0, 0, 0));
      seq.push_back(mk(1, 4'hF, 0, 1, 0, 0));
      seq.push_back(mk(1, 4'hF, 0, 1, 1, 0));
`endif
      foreach (seq[n]) begin
         drive_cycle(seq[n]);
         @(negedge clk);
         e = exp_q.pop_front();
         o = {o_wren, o_grant_id, o_busy, o_req_ready, o_wrdata};
         x = exp_vec(e);
         checks++;
         if (o !== x) begin
            errors++;
            $display("FAIL mid_reset cyc%0d: got wren=%0b id=%0d busy=%0b rdy=%b data=%h, expected wren=%0b id=%0d busy=%0b rdy=%b data=%h",
                     n, o[135], o[134:133], o[132], o[131:128], o[127:0],
                     x[135], x[134:133], x[132], x[131:128], x[127:0]);
         end
      end
   endtask

   initial begin
      rstn        = 1'b0;
      i_req_valid = '0;
      i_full      = 1'b0;
      for (int k = 0; k < NUM_REQ; k++) i_req_data[k*DATA_W +: DATA_W] = data_of(k);

      test_reset();
`ifdef FIFO_WR_ARB_BURST_EN
      test_burst();
      test_full();
      test_owner_drop();
`else
      test_round_robin();
      test_full();
`endif
      test_mid_reset();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish within the time limit");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Round-robin write-port arbiter that shares one 128-bit FIFO write port among `NUM_REQ` producers. Each producer presents a valid/ready stream. The arbiter selects one producer at a time, optionally locks it for a burst of up to `MAX_BURST` beats, and drives the FIFO `wren`/`wrdata` directly. It sits between the producer blocks and the FIFO write side and is the only agent allowed to write the FIFO.

## Interface
Parameters:
- `NUM_REQ`, 4 — number of producers, 2..8.
- `DATA_W`, 128 — beat width; matches the FIFO data width.
- `MAX_BURST`, 4 — maximum beats per burst grant, 1..16.

Ports:
- `clk`  input  1 — single clock, all logic on posedge.
- `rstn`  input  1 — synchronous, active-low reset.
- `i_req_valid`  input  NUM_REQ — per-producer beat valid.
- `i_req_data`  input  NUM_REQ*DATA_W — flattened beats; producer k occupies bits [k*DATA_W +: DATA_W].
- `o_req_ready`  output  NUM_REQ — per-producer accept; at most one bit set.
- `i_full`  input  1 — FIFO full.
- `o_wren`  output  1 — FIFO write enable.
- `o_wrdata`  output  DATA_W — FIFO write data.
- `o_grant_id`  output  $clog2(NUM_REQ) — index of the producer written this cycle (debug); 0 when `o_wren`=0.
- `o_busy`  output  1 — registered; high while in the BURST state.

## Operation
- Transfer on producer k: `i_req_valid[k] & o_req_ready[k]`. On a transfer, `o_wren`=1 and `o_wrdata`=data[k] in the same cycle.
- `o_req_ready[k]` is asserted only when `i_req_valid[k]`=1, producer k is the winner, and `i_full`=0.
- `o_wren` is never asserted while `i_full`=1.
- Producers must hold valid and data stable until ready. The arbiter does not check this.
- State register has two states: IDLE and BURST. Additional registers:
  - `rr_ptr` (highest-priority index)
  - `owner`
  - `beat_cnt` (width $clog2(MAX_BURST+1))
- IDLE:
  - Winner = first k with valid set, scanning `rr_ptr`, `rr_ptr`+1, … modulo NUM_REQ.
  - If a winner exists and `i_full`=0: transfer, `rr_ptr` ← winner+1 mod NUM_REQ, `owner` ← winner, `beat_cnt` ← 1.
  - After that transfer, go to BURST if MAX_BURST>1; otherwise stay in IDLE.
- BURST:
  - Only `owner` is eligible.
  - Transfer with `beat_cnt`+1 == MAX_BURST: `beat_cnt` ← 0, go to IDLE.
  - Any other transfer: `beat_cnt` increments.
  - `i_full`=1 with owner valid: hold all state, no write.
  - Owner valid low, regardless of `i_full`: release to IDLE with `beat_cnt` ← 0. No write this cycle, and other producers are not serviced this cycle.
- `rr_ptr` updates only on an IDLE-state grant.
- Reset values: state IDLE, `rr_ptr`=0, `owner`=0, `beat_cnt`=0, `o_busy`=0. Combinational outputs then evaluate to `o_wren`=0, `o_req_ready`=0, `o_grant_id`=0, `o_wrdata`=0.
- Reset overrides everything, including mid-burst. No write occurs in any cycle where `rstn`=0.

## Timing
- Data path is combinational: zero-cycle latency from producer beat to FIFO write.
- Arbitration state updates on the posedge following the transfer.
- Throughput is one beat per cycle while the selected producer is valid and the FIFO is not full.
- Burst-to-burst handoff costs no idle cycle when the last beat hits MAX_BURST: the next IDLE cycle grants immediately.
- Owner-drop release costs exactly one idle cycle.
- `o_busy` is registered and reflects the state at cycle start.

## Configuration
- `FIFO_WR_ARB_BURST_EN` defined: burst locking behaves as described above.
- Macro undefined: the BURST state is not compiled in.
  - Every beat is arbitrated in IDLE, and `rr_ptr` advances per beat, giving strict per-beat round-robin.
  - `MAX_BURST` is ignored, and `o_busy` is tied 0.

## Test plan
- Reset: hold `rstn`=0 for 3 cycles with all valids high → `o_wren`=0, `o_req_ready`=0 throughout. The first cycle after release writes producer 0's data with `o_grant_id`=0.
- Per-beat round-robin (macro undefined): all 4 producers valid, producer k data = k → `o_wrdata` sequence 0,1,2,3,0,1 on consecutive cycles.
- Burst (macro defined, MAX_BURST=4): producers 1 and 2 continuously valid → four consecutive writes from 1, then four from 2, then 1 again. `o_busy`=1 from the 2nd through the 4th beat of each burst.
- FIFO full: `i_full`=1 for 3 cycles after beat 2 of producer 0's burst → `o_wren`=0 and ready=0 for those 3 cycles. Beats 3–4 then come from producer 0, then producer 1.
- Owner drop: producer 0 drops valid after 2 beats while producer 3 is valid → one cycle with `o_wren`=0, then producer 1's burst if valid, otherwise producer 3's burst.
- Mid-burst reset: assert `rstn`=0 for 1 cycle during producer 2's burst → no write that cycle, `o_busy`=0 next cycle, and the next grant scans from producer 0.
